ila_readout_ctrl: RTL and testbench

- Sequences the post-capture readout of the circular sample BRAM into the sample-to-byte serialiser.
- Computes the window start address from the trigger address and the pre-trigger length, and preloads the first sample.
- Owns the serialiser's read-active enable and advances the BRAM address on each serialiser reload pulse.
- Ends the readout after a programmed number of samples. Sits between the ILA config/command decoder, the capture BRAM read port and the serialiser.

---
 rtl/ila_pkg.sv | 34 +++
 rtl/ila_addr_wrap.sv | 37 +++
 rtl/ila_readout_ctrl.sv | 139 +++++++++++++
 tb/tb_ila_readout_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ila_pkg.sv
// Shared ILA definitions: address width, readout state encoding and
// modulo-depth address arithmetic for BRAMs whose depth need not be 2^n.
package ila_pkg;

  localparam int ram_depth_max = 1024;
  localparam int addr_width    = $clog2(ram_depth_max);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CALC    = 3'd1;
  localparam logic [2:0] PRELOAD = 3'd2;
  localparam logic [2:0] ACTIVE  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  function automatic logic [addr_width-1:0] wrap_inc(
    input logic [addr_width-1:0] a,
    input logic [addr_width:0]   depth
  );
    if ({1'b0, a} == depth - (addr_width+1)'(1)) return '0;
    return a + addr_width'(1);
  endfunction

  // Result of a - b folded back into 0..depth-1 without a modulo operator.
  function automatic logic [addr_width-1:0] wrap_sub(
    input logic [addr_width-1:0] a,
    input logic [addr_width-1:0] b,
    input logic [addr_width:0]   depth
  );
    logic [addr_width:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + depth - {1'b0, b};
    return t[addr_width-1:0];
  endfunction

endpackage

// File: rtl/ila_addr_wrap.sv
// Registered modulo-ram_depth address generator; priority is load, then
// subtract, then increment.
module ila_addr_wrap
  import ila_pkg::*;
#(
  parameter int ram_depth = 1024
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [addr_width-1:0] load_val_i,
  input  logic                  inc_i,
  input  logic                  sub_i,
  input  logic [addr_width-1:0] sub_a_i,
  input  logic [addr_width-1:0] sub_b_i,
  output logic [addr_width-1:0] addr_o
);

  localparam logic [addr_width:0] depth_w = (addr_width+1)'(ram_depth);

  logic [addr_width-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i)     addr_d = load_val_i;
    else if (sub_i) addr_d = wrap_sub(sub_a_i, sub_b_i, depth_w);
    else if (inc_i) addr_d = wrap_inc(addr_q, depth_w);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) addr_q <= '0;
    else         addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/ila_readout_ctrl.sv
// Post-capture readout sequencer: walks the circular sample BRAM window
// and paces it into the sample-to-byte serialiser via its reload pulses.
module ila_readout_ctrl
  import ila_pkg::*;
#(
  parameter int ram_depth   = 1024,
  parameter int ram_latency = 1
) (
  input  logic                  i_clk_ILA,
  input  logic                  i_reset,
  input  logic                  i_start_readout,
  input  logic                  i_abort,
  input  logic [addr_width-1:0] i_trigger_addr,
  input  logic [addr_width-1:0] i_pre_trigger,
  input  logic [addr_width:0]   i_sample_cnt,
  input  logic                  i_rd,
  output logic                  o_read_active,
  output logic [addr_width-1:0] o_ram_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [addr_width:0]   o_samples_sent,
  output logic [2:0]            o_dbg_state
);

  localparam logic [addr_width:0] depth_w = (addr_width+1)'(ram_depth);
  localparam logic [1:0]          lat_w   = 2'(ram_latency);

  logic [2:0]            state_q, state_d;
  logic [addr_width-1:0] trig_q, trig_d, pre_q, pre_d;
  logic [addr_width:0]   cnt_q, cnt_d, sent_q, sent_d, sent_inc;
  logic [1:0]            wait_q, wait_d;
  logic                  ra_q, ra_d;
  logic                  addr_sub, addr_inc;
  logic                  abort_hit;

  assign abort_hit = i_abort && (state_q != IDLE);
  assign sent_inc  = sent_q + (addr_width+1)'(1);

  always_ff @(posedge i_clk_ILA) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_start_readout) state_d = CALC;
        CALC:    state_d = PRELOAD;
        PRELOAD: if (wait_q == 2'd0) state_d = ACTIVE;
        ACTIVE:  if (i_rd && (sent_inc == cnt_q)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The serialiser keeps reloading while read_active is low, so PRELOAD only
  // has to hold the start address long enough for the BRAM data to arrive.
  always_comb begin
    trig_d   = trig_q;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    sent_d   = sent_q;
    wait_d   = wait_q;
    ra_d     = ra_q;
    addr_sub = 1'b0;
    addr_inc = 1'b0;
    if (abort_hit) begin
      ra_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_start_readout) begin
          trig_d = i_trigger_addr;
          pre_d  = i_pre_trigger;
          cnt_d  = (i_sample_cnt == '0) ? depth_w : i_sample_cnt;
          sent_d = '0;
        end
        CALC: begin
          addr_sub = 1'b1;
          wait_d   = lat_w;
        end
        PRELOAD: begin
          if (wait_q == 2'd0) begin
            ra_d     = 1'b1;
            addr_inc = 1'b1;
          end else begin
            wait_d = wait_q - 2'd1;
          end
        end
        ACTIVE: if (i_rd) begin
          sent_d = sent_inc;
          if (sent_inc == cnt_q) ra_d = 1'b0;
          else                   addr_inc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk_ILA) begin
    if (i_reset) begin
      trig_q <= '0;
      pre_q  <= '0;
      cnt_q  <= '0;
      sent_q <= '0;
      wait_q <= '0;
      ra_q   <= 1'b0;
    end else begin
      trig_q <= trig_d;
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      sent_q <= sent_d;
      wait_q <= wait_d;
      ra_q   <= ra_d;
    end
  end

  ila_addr_wrap #(.ram_depth(ram_depth)) u_addr (
    .clk_i      (i_clk_ILA),
    .reset_i    (i_reset),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (addr_inc),
    .sub_i      (addr_sub),
    .sub_a_i    (trig_q),
    .sub_b_i    (pre_q),
    .addr_o     (o_ram_addr)
  );

  assign o_read_active  = ra_q;
  assign o_samples_sent = sent_q;
  assign o_dbg_state    = state_q;
  assign o_busy         = (state_q != IDLE);
  assign o_done         = (state_q == DONE);

endmodule

// File: tb/tb_ila_readout_ctrl.sv
// Directed bench: a 1024-deep latency-1 instance driven by hand, and a
// 600-deep latency-2 instance run against a BRAM ramp and a byte serialiser.
module tb_ila_readout_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // instance A: ram_depth 1024, ram_latency 1
  logic        a_reset = 1'b1, a_start = 1'b0, a_abort = 1'b0, a_rd = 1'b0;
  logic [9:0]  a_trig = '0, a_pre = '0;
  logic [10:0] a_cnt = '0;
  logic        a_ra, a_busy, a_done;
  logic [9:0]  a_addr;
  logic [10:0] a_sent;
  logic [2:0]  a_dbg;

  ila_readout_ctrl #(.ram_depth(1024), .ram_latency(1)) dut_a (
    .i_clk_ILA(clk), .i_reset(a_reset), .i_start_readout(a_start),
    .i_abort(a_abort), .i_trigger_addr(a_trig), .i_pre_trigger(a_pre),
    .i_sample_cnt(a_cnt), .i_rd(a_rd), .o_read_active(a_ra),
    .o_ram_addr(a_addr), .o_busy(a_busy), .o_done(a_done),
    .o_samples_sent(a_sent), .o_dbg_state(a_dbg)
  );

  // instance B: ram_depth 600, ram_latency 2, with BRAM and serialiser models
  logic        b_reset = 1'b1, b_start = 1'b0, b_abort = 1'b0, b_rd = 1'b0;
  logic [9:0]  b_trig = '0, b_pre = '0;
  logic [10:0] b_cnt = '0;
  logic        b_ra, b_busy, b_done;
  logic [9:0]  b_addr;
  logic [10:0] b_sent;
  logic [2:0]  b_dbg;

  ila_readout_ctrl #(.ram_depth(600), .ram_latency(2)) dut_b (
    .i_clk_ILA(clk), .i_reset(b_reset), .i_start_readout(b_start),
    .i_abort(b_abort), .i_trigger_addr(b_trig), .i_pre_trigger(b_pre),
    .i_sample_cnt(b_cnt), .i_rd(b_rd), .o_read_active(b_ra),
    .o_ram_addr(b_addr), .o_busy(b_busy), .o_done(b_done),
    .o_samples_sent(b_sent), .o_dbg_state(b_dbg)
  );

  function automatic logic [23:0] ram_val(input int a);
    return 24'(a * 257) + 24'h300000;
  endfunction

  logic [23:0] r1 = '0, r2 = '0, ser_shift = '0;
  int          ser_tick = 0;
  int          rd_cnt = 0, done_cnt = 0, wraps = 0;
  logic [9:0]  b_prev = '0;
  logic [7:0]  obs_q[$];
  logic [7:0]  exp_q[$];

  always @(posedge clk) begin
    r1 <= ram_val(int'(b_addr));
    r2 <= r1;
  end

  // One byte every 4 cycles; on the third byte reload and pulse rd next cycle.
  always @(posedge clk) begin
    b_rd <= 1'b0;
    if (!b_ra) begin
      ser_shift <= r2;
      ser_tick  <= 0;
    end else begin
      ser_tick <= (ser_tick == 11) ? 0 : ser_tick + 1;
      if (ser_tick == 3) obs_q.push_back(ser_shift[7:0]);
      if (ser_tick == 7) obs_q.push_back(ser_shift[15:8]);
      if (ser_tick == 11) begin
        obs_q.push_back(ser_shift[23:16]);
        ser_shift <= r2;
        b_rd      <= 1'b1;
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (b_done) done_cnt = done_cnt + 1;
    if (b_prev == 10'd599 && b_addr == 10'd0) wraps = wraps + 1;
    b_prev = b_addr;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_start_run(input int trig, input int pre, input int cnt);
    a_trig  = 10'(trig);
    a_pre   = 10'(pre);
    a_cnt   = 11'(cnt);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_rd_pulse(input int gap);
    repeat (gap) tick();
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
  endtask

  task automatic a_wait_active;
    int n;
    n = 0;
    while (!a_ra && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (a_ra !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_active: read_active=%0b after %0d cycles, required 1", a_ra, n);
    end
  endtask

  task automatic test_reset;
    a_reset = 1'b1; b_reset = 1'b1;
    a_start = 1'b1; a_rd = 1'b1;
    tick(); tick();
    n_checks++; if (a_ra !== 1'b0) begin n_fail++; $display("FAIL reset_read_active: got %0b, required 0", a_ra); end
    n_checks++; if (a_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", a_addr); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", a_busy); end
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b, required 0", a_done); end
    n_checks++; if (a_sent !== 11'd0) begin n_fail++; $display("FAIL reset_sent: got %0d, required 0", a_sent); end
    n_checks++; if (a_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", a_dbg); end
    n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_b_busy: got %0b, required 0", b_busy); end
    a_start = 1'b0; a_rd = 1'b0;
    a_reset = 1'b0; b_reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int exp_addr;
    a_start_run(100, 20, 4);
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b, required 1", a_busy); end
    tick();
    n_checks++; if (a_addr !== 10'd80) begin n_fail++; $display("FAIL basic_preload_addr: got %0d, required 80", a_addr); end
    tick();
    n_checks++; if (a_ra !== 1'b0) begin n_fail++; $display("FAIL basic_preload_hold: read_active=%0b, required 0", a_ra); end
    tick();
    n_checks++; if (a_ra !== 1'b1) begin n_fail++; $display("FAIL basic_active: read_active=%0b, required 1", a_ra); end
    n_checks++; if (a_addr !== 10'd81) begin n_fail++; $display("FAIL basic_prefetch_addr: got %0d, required 81", a_addr); end
    for (int i = 1; i <= 3; i++) begin
      a_rd_pulse(39);
      exp_addr = 81 + i;
      n_checks++; if (a_addr !== 10'(exp_addr)) begin n_fail++; $display("FAIL basic_step_addr[%0d]: got %0d, required %0d", i, a_addr, exp_addr); end
      n_checks++; if (a_sent !== 11'(i)) begin n_fail++; $display("FAIL basic_step_sent[%0d]: got %0d, required %0d", i, a_sent, i); end
    end
    a_rd_pulse(39);
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0b, required 1", a_done); end
    n_checks++; if (a_sent !== 11'd4) begin n_fail++; $display("FAIL basic_sent: got %0d, required 4", a_sent); end
    n_checks++; if (a_ra !== 1'b0) begin n_fail++; $display("FAIL basic_ra_off: got %0b, required 0", a_ra); end
    n_checks++; if (a_addr !== 10'd84) begin n_fail++; $display("FAIL basic_final_addr: got %0d, required 84", a_addr); end
    tick();
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %0b, required 0", a_done); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy=%0b, required 0", a_busy); end
    n_checks++; if (a_addr !== 10'd84) begin n_fail++; $display("FAIL basic_addr_hold: got %0d, required 84", a_addr); end
  endtask

  task automatic test_wrap;
    int exp_addr;
    a_start_run(5, 10, 8);
    tick();
    n_checks++; if (a_addr !== 10'd1019) begin n_fail++; $display("FAIL wrap_start_addr: got %0d, required 1019", a_addr); end
    a_wait_active();
    n_checks++; if (a_addr !== 10'd1020) begin n_fail++; $display("FAIL wrap_prefetch: got %0d, required 1020", a_addr); end
    for (int i = 1; i <= 7; i++) begin
      a_rd_pulse(3);
      exp_addr = (1020 + i) % 1024;
      n_checks++; if (a_addr !== 10'(exp_addr)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d, required %0d", i, a_addr, exp_addr); end
      n_checks++; if (a_ra !== 1'b1) begin n_fail++; $display("FAIL wrap_ra[%0d]: got %0b, required 1", i, a_ra); end
    end
    a_rd_pulse(3);
    n_checks++; if (a_ra !== 1'b0) begin n_fail++; $display("FAIL wrap_ra_drop: got %0b, required 0", a_ra); end
    n_checks++; if (a_addr !== 10'd3) begin n_fail++; $display("FAIL wrap_final_addr: got %0d, required 3", a_addr); end
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %0b, required 1", a_done); end
    tick();
  endtask

  task automatic test_abort;
    a_start_run(200, 50, 10);
    a_wait_active();
    a_rd_pulse(4);
    a_rd_pulse(4);
    a_abort = 1'b1;
    a_rd    = 1'b1;
    tick();
    a_abort = 1'b0;
    a_rd    = 1'b0;
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy=%0b, required 0", a_busy); end
    n_checks++; if (a_ra !== 1'b0) begin n_fail++; $display("FAIL abort_ra: got %0b, required 0", a_ra); end
    n_checks++; if (a_sent !== 11'd2) begin n_fail++; $display("FAIL abort_sent: got %0d, required 2", a_sent); end
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0b, required 0", a_done); end
    tick();
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %0b, required 0", a_done); end
    a_start_run(10, 0, 1);
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL abort_restart_busy: got %0b, required 1", a_busy); end
    n_checks++; if (a_sent !== 11'd0) begin n_fail++; $display("FAIL abort_restart_sent: got %0d, required 0", a_sent); end
    tick();
    n_checks++; if (a_addr !== 10'd10) begin n_fail++; $display("FAIL abort_restart_addr: got %0d, required 10", a_addr); end
    a_wait_active();
    a_rd_pulse(2);
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL abort_restart_done: got %0b, required 1", a_done); end
    n_checks++; if (a_addr !== 10'd11) begin n_fail++; $display("FAIL abort_restart_final: got %0d, required 11", a_addr); end
    tick();
  endtask

  task automatic test_reset_mid;
    a_start_run(300, 0, 10);
    a_wait_active();
    a_rd_pulse(5);
    n_checks++; if (a_addr !== 10'd302) begin n_fail++; $display("FAIL mid_addr: got %0d, required 302", a_addr); end
    a_trig  = 10'd7;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n_checks++; if (a_addr !== 10'd302) begin n_fail++; $display("FAIL busy_start_addr: got %0d, required 302", a_addr); end
    n_checks++; if (a_dbg !== 3'd3) begin n_fail++; $display("FAIL busy_start_state: got %0d, required 3", a_dbg); end
    n_checks++; if (a_sent !== 11'd1) begin n_fail++; $display("FAIL busy_start_sent: got %0d, required 1", a_sent); end
    a_reset = 1'b1;
    a_rd    = 1'b1;
    tick();
    a_reset = 1'b0;
    a_rd    = 1'b0;
    n_checks++; if (a_ra !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ra: got %0b, required 0", a_ra); end
    n_checks++; if (a_addr !== 10'd0) begin n_fail++; $display("FAIL mid_reset_addr: got %0d, required 0", a_addr); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %0b, required 0", a_busy); end
    n_checks++; if (a_sent !== 11'd0) begin n_fail++; $display("FAIL mid_reset_sent: got %0d, required 0", a_sent); end
    tick();
  endtask

  task automatic test_cosim;
    logic [23:0] v;
    int n, bad;
    for (int i = 0; i < 600; i++) begin
      v = ram_val((0 + i) % 600);
      exp_q.push_back(v[7:0]);
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[23:16]);
    end
    b_trig  = 10'd3;
    b_pre   = 10'd3;
    b_cnt   = 11'd600;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      tick();
      n++;
    end
    repeat (20) tick();
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL cosim_done_count: got %0d, required 1", done_cnt); end
    n_checks++; if (rd_cnt !== 600) begin n_fail++; $display("FAIL cosim_rd_count: got %0d, required 600", rd_cnt); end
    n_checks++; if (wraps !== 1) begin n_fail++; $display("FAIL cosim_wraps: got %0d, required 1", wraps); end
    n_checks++; if (b_sent !== 11'd600) begin n_fail++; $display("FAIL cosim_sent: got %0d, required 600", b_sent); end
    n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL cosim_idle: busy=%0b, required 0", b_busy); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL cosim_byte_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        bad++;
        if (bad <= 10) $display("FAIL cosim_byte[%0d]: got %02h, required %02h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_cosim();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
